// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - job sequencer for a BRAM-backed matrix-multiply datapath
// Define MATMUL_SEQ_CTRL_TIMEOUT_EN to add the COMPUTE watchdog, err flag and ABORT state.
module matmul_seq_ctrl #(
  parameter int ROWS    = 16,
  parameter int AWIDTH  = 7,
  parameter int RWIDTH  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              job_start,
  output logic              busy,
  output logic              job_done,
  output logic              err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              start_mat_mul,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [RWIDTH-1:0] data_pi,
  input  logic              done_mat_mul,
  input  logic [RWIDTH-1:0] data_from_out_mat
);

  localparam int            CW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_FLUSH, S_COMPUTE, S_DRAIN, S_ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_FLUSH, S_COMPUTE, S_DRAIN
  } state_t;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_row;
  logic                r_flush;
  logic                r_wv1;
  logic                r_wv2;
  logic                r_wb1;
  logic                r_wb2;
  logic [RWIDTH-1:0]   r_wd1;
  logic [RWIDTH-1:0]   r_wd2;
  logic [2:0]          r_rd_pipe;
  logic                r_out_vld;
  logic [RWIDTH-1:0]   r_out_data;
  logic                r_done;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_issue;
  logic                w_row_last;
  logic                w_wr_win;
  logic                w_abort;

  assign w_row_last = (r_row == LAST_ROW);
  assign w_in_hs    = in_valid & in_ready;
  assign w_out_hs   = r_out_vld & out_ready & (r_state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (job_start) w_next = S_LOAD_A;
      S_LOAD_A:  if (w_in_hs && w_row_last) w_next = S_LOAD_B;
      S_LOAD_B:  if (w_in_hs && w_row_last) w_next = S_FLUSH;
      S_FLUSH:   if (r_flush) w_next = S_COMPUTE;
      S_COMPUTE: begin
        if (done_mat_mul) w_next = S_DRAIN;
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
        else if (w_abort) w_next = S_ABORT;
`endif
      end
      S_DRAIN:   if (w_out_hs && w_row_last) w_next = S_IDLE;
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
      S_ABORT:   w_next = S_IDLE;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  // Reads are strictly one at a time: issue only when nothing is in flight or held.
  always_comb begin
    busy                    = (r_state != S_IDLE);
    in_ready                = 1'b0;
    enable_writing_to_mem   = 1'b0;
    enable_reading_from_mem = 1'b0;
    start_mat_mul           = 1'b0;
    we_c                    = 1'b0;
    addr_pi                 = '0;
    w_issue                 = 1'b0;
    w_wr_win                = 1'b0;
    case (r_state)
      S_LOAD_A, S_LOAD_B: begin
        in_ready              = 1'b1;
        enable_writing_to_mem = 1'b1;
        w_wr_win              = 1'b1;
        if (in_valid) addr_pi = AWIDTH'(r_row);
      end
      S_FLUSH: begin
        enable_writing_to_mem = 1'b1;
        w_wr_win              = 1'b1;
      end
      S_COMPUTE: begin
        start_mat_mul = 1'b1;
        we_c          = 1'b1;
      end
      S_DRAIN: begin
        enable_reading_from_mem = 1'b1;
        w_issue                 = ~r_out_vld & ~(|r_rd_pipe);
        if (w_issue) addr_pi    = AWIDTH'(r_row);
      end
      default: ;
    endcase
    we_a = r_wv2 & ~r_wb2 & w_wr_win;
    we_b = r_wv2 &  r_wb2 & w_wr_win;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_row      <= '0;
      r_flush    <= 1'b0;
      r_wv1      <= 1'b0;
      r_wv2      <= 1'b0;
      r_wb1      <= 1'b0;
      r_wb2      <= 1'b0;
      r_wd1      <= '0;
      r_wd2      <= '0;
      r_rd_pipe  <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_done     <= 1'b0;
    end else begin
      // Two-stage write pipeline mirrors the datapath address registers.
      r_wv1 <= w_in_hs;
      r_wb1 <= (r_state == S_LOAD_B);
      if (w_in_hs) r_wd1 <= in_data;
      r_wv2 <= r_wv1;
      r_wb2 <= r_wb1;
      if (r_wv1) r_wd2 <= r_wd1;

      r_flush   <= (r_state == S_FLUSH) && !r_flush;
      r_rd_pipe <= {r_rd_pipe[1:0], w_issue};
      r_done    <= (w_out_hs && w_row_last) || w_abort;

      if (r_rd_pipe[2]) begin
        r_out_vld  <= 1'b1;
        r_out_data <= data_from_out_mat;
      end else if (w_out_hs) begin
        r_out_vld  <= 1'b0;
      end

      if (r_state == S_IDLE && job_start) r_row <= '0;
      else if (w_in_hs || w_out_hs)      r_row <= w_row_last ? '0 : r_row + 1'b1;
    end
  end

`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_COMPUTE) r_tmo <= r_tmo + 1'b1;
      else                      r_tmo <= '0;
      if (r_state == S_IDLE && job_start) r_err <= 1'b0;
      else if (w_abort)                   r_err <= 1'b1;
    end
  end

  assign w_abort = (r_state == S_COMPUTE) && !done_mat_mul && (r_tmo == TW'(TIMEOUT - 1));
  assign err     = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_abort          = 1'b0;
  assign err              = 1'b0;
`endif

  assign out_valid = r_out_vld;
  assign out_data  = r_out_data;
  assign out_last  = r_out_vld & w_row_last;
  assign data_pi   = r_wd2;
  assign job_done  = r_done;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - directed self-checking bench for matmul_seq_ctrl
module tb_matmul_seq_ctrl;
  localparam int ROWS   = 16;
  localparam int AWIDTH = 7;
  localparam int RWIDTH = 256;
`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
  localparam int TIMEOUT = 64;
`else
  localparam int TIMEOUT = 1024;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              job_start;
  logic              busy, job_done, err;
  logic              in_valid, in_ready;
  logic [RWIDTH-1:0] in_data;
  logic              out_valid, out_ready, out_last;
  logic [RWIDTH-1:0] out_data;
  logic              enable_writing_to_mem, enable_reading_from_mem;
  logic              we_a, we_b, we_c, start_mat_mul;
  logic [AWIDTH-1:0] addr_pi;
  logic [RWIDTH-1:0] data_pi;
  logic              done_mat_mul;
  logic [RWIDTH-1:0] data_from_out_mat;

  matmul_seq_ctrl #(.ROWS(ROWS), .AWIDTH(AWIDTH), .RWIDTH(RWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .job_start(job_start), .busy(busy), .job_done(job_done),
    .err(err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .enable_writing_to_mem(enable_writing_to_mem), .enable_reading_from_mem(enable_reading_from_mem),
    .we_a(we_a), .we_b(we_b), .we_c(we_c), .start_mat_mul(start_mat_mul),
    .addr_pi(addr_pi), .data_pi(data_pi), .done_mat_mul(done_mat_mul),
    .data_from_out_mat(data_from_out_mat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [RWIDTH-1:0] got, input logic [RWIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RWIDTH-1:0] rd_val(input int a);
    rd_val = {8{16'hC0DE, a[15:0]}};
  endfunction

  logic [RWIDTH-1:0] mem_a [ROWS];
  logic [RWIDTH-1:0] mem_b [ROWS];
  int                a_addrs[$];
  int                b_addrs[$];
  int                n_we_a = 0, n_we_b = 0, n_jd = 0, n_wr_bad = 0;
  logic              hs_d1 = 1'b0, hs_d2 = 1'b0;
  logic [AWIDTH-1:0] ad_d1 = '0, ad_d2 = '0;
  logic [RWIDTH-1:0] dt_d1 = '0, dt_d2 = '0;
  logic [AWIDTH-1:0] h0 = '0, h1 = '0, h2 = '0, h3 = '0;

  // Datapath model: write lands 2 cycles after its address, read data appears 3 cycles after.
  always @(negedge clk) begin
    if (we_a || we_b) begin
      if (!hs_d2 || data_pi !== dt_d2 || (we_a && we_b) || !busy) n_wr_bad++;
      if (we_a) begin
        n_we_a++;
        a_addrs.push_back(int'(ad_d2));
        if (int'(ad_d2) < ROWS) mem_a[ad_d2] = data_pi;
      end
      if (we_b) begin
        n_we_b++;
        b_addrs.push_back(int'(ad_d2));
        if (int'(ad_d2) < ROWS) mem_b[ad_d2] = data_pi;
      end
    end
    if (job_done) n_jd++;
    hs_d2 = hs_d1; ad_d2 = ad_d1; dt_d2 = dt_d1;
    hs_d1 = in_valid && in_ready; ad_d1 = addr_pi; dt_d1 = in_data;
    h3 = h2; h2 = h1; h1 = h0; h0 = addr_pi;
    data_from_out_mat = rd_val(int'(h3));
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, job_done, err, in_ready, out_valid, out_last, enable_writing_to_mem,
                          enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul}, '0);
    check({tag, "_addr"}, addr_pi, '0);
    check({tag, "_data_pi"}, data_pi, '0);
    check({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic push_row(input logic [RWIDTH-1:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("push_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_rows(input int base, input bit gap);
    for (int i = 0; i < ROWS; i++) begin
      push_row(RWIDTH'(base + i));
      if (gap && i < ROWS - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic start_job();
    @(posedge clk); #1;
    a_addrs.delete();
    b_addrs.delete();
    job_start = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic compute_phase(input int done_cyc, input bit poke);
    @(negedge clk);
    check("flush1_in_ready", in_ready, 0);
    check("flush1_wr_en", enable_writing_to_mem, 1);
    @(negedge clk);
    check("flush2_start", start_mat_mul, 0);
    @(negedge clk);
    check("compute_start_we_c", {start_mat_mul, we_c}, 2'b11);
    for (int c = 2; c <= done_cyc; c++) begin
      @(negedge clk);
      job_start = poke && (c == 5);
    end
    done_mat_mul = 1'b1;
    check("done_cycle_start", {start_mat_mul, we_c}, 2'b11);
    @(negedge clk);
    done_mat_mul = 1'b0;
    check("after_done_start_we_c", {start_mat_mul, we_c}, 2'b00);
    check("drain_rd_en", enable_reading_from_mem, 1);
  endtask

  task automatic drain_phase(input int stall_row);
    for (int r = 0; r < ROWS; r++) begin
      int k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("out_valid_r%0d", r), out_valid, 1);
      check($sformatf("out_data_r%0d", r), out_data, rd_val(r));
      check($sformatf("out_last_r%0d", r), out_last, (r == ROWS - 1));
      if (r == stall_row) begin
        logic [RWIDTH-1:0] held;
        int bad = 0;
        held = out_data;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!out_valid || out_data !== held || (enable_reading_from_mem && addr_pi == 7'd4)) bad++;
        end
        check("stall_hold", bad, 0);
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_job(input int base_a, input int base_b, input int jd0, input int wa0, input int wb0);
    repeat (2) @(negedge clk);
    check("we_a_count", n_we_a - wa0, ROWS);
    check("we_b_count", n_we_b - wb0, ROWS);
    check("a_addr_count", a_addrs.size(), ROWS);
    check("b_addr_count", b_addrs.size(), ROWS);
    for (int i = 0; i < a_addrs.size(); i++) check($sformatf("a_addr_%0d", i), a_addrs[i], i);
    for (int i = 0; i < b_addrs.size(); i++) check($sformatf("b_addr_%0d", i), b_addrs[i], i);
    for (int i = 0; i < ROWS; i++) begin
      check($sformatf("mem_a_%0d", i), mem_a[i], RWIDTH'(base_a + i));
      check($sformatf("mem_b_%0d", i), mem_b[i], RWIDTH'(base_b + i));
    end
    check("job_done_count", n_jd - jd0, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int jd0, wa0, wb0, snap;
    resetn = 1'b0; job_start = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; done_mat_mul = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Job 1: back-to-back rows, done after 40 compute cycles.
    jd0 = n_jd; wa0 = n_we_a; wb0 = n_we_b;
    start_job();
    load_rows(0, 1'b0);
    load_rows('h100, 1'b0);
    compute_phase(40, 1'b0);
    drain_phase(-1);
    check_job(0, 'h100, jd0, wa0, wb0);

    // Reset in LOAD_B with the counter at row 7.
    start_job();
    load_rows('h300, 1'b0);
    for (int i = 0; i < 7; i++) push_row(RWIDTH'('h400 + i));
    in_valid = 1'b1;
    in_data  = RWIDTH'('h407);
    resetn   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midjob_reset");
    in_valid = 1'b0;
    resetn   = 1'b1;
    snap = n_we_a + n_we_b;
    repeat (4) @(negedge clk);
    check("no_write_after_reset", n_we_a + n_we_b - snap, 0);

    // Job 2: gapped input, job_start poked in COMPUTE, row 3 back-pressured.
    jd0 = n_jd; wa0 = n_we_a; wb0 = n_we_b;
    start_job();
    load_rows('h200, 1'b1);
    load_rows('h500, 1'b1);
    compute_phase(12, 1'b1);
    drain_phase(3);
    check_job('h200, 'h500, jd0, wa0, wb0);

    // done_mat_mul in IDLE must be ignored.
    jd0 = n_jd;
    @(posedge clk); #1;
    done_mat_mul = 1'b1;
    @(posedge clk); #1;
    done_mat_mul = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_busy", busy, 0);
    check("idle_done_no_job_done", n_jd - jd0, 0);

`ifdef MATMUL_SEQ_CTRL_TIMEOUT_EN
    jd0 = n_jd;
    start_job();
    load_rows('h600, 1'b0);
    load_rows('h700, 1'b0);
    repeat (3) @(negedge clk);
    check("tmo_compute_c1", start_mat_mul, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("tmo_compute_last", {start_mat_mul, err}, 2'b10);
    @(negedge clk);
    check("tmo_abort", {busy, start_mat_mul, we_c, err, job_done}, 5'b10011);
    @(negedge clk);
    check("tmo_idle", {busy, err, job_done}, 3'b010);
    check("tmo_job_done_count", n_jd - jd0, 1);
    start_job();
    check("tmo_err_cleared", err, 0);
`endif

    check("write_timing", n_wr_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 SHALL have parameters: ROWS, default 16, rows per matrix; AWIDTH, default 7, BRAM address width; RWIDTH, default 256, row width in bits; TIMEOUT, default 1024, watchdog cycles.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 resetn  in  1  synchronous, active-low reset.
REQ-004 job_start  in  1  one-cycle job request, honoured only in IDLE.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 job_done  out  1  one-cycle pulse on job completion or abort.
REQ-007 err  out  1  sticky timeout flag, cleared by the next accepted job_start.
REQ-008 in_valid / in_ready  in / out  1 / 1  host row-write handshake.
REQ-009 in_data  in  RWIDTH  host row, A rows first, then B rows.
REQ-010 out_valid / out_ready  out / in  1 / 1  result row handshake.
REQ-011 out_data  out  RWIDTH  C row; out_last  out  1  marks row ROWS-1.
REQ-012 enable_writing_to_mem, enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul  out  1 each  datapath controls.
REQ-013 addr_pi  out  AWIDTH; data_pi  out  RWIDTH; done_mat_mul  in  1; data_from_out_mat  in  RWIDTH.

Function
REQ-014 The FSM SHALL use the states IDLE, LOAD_A, LOAD_B, FLUSH, COMPUTE, DRAIN, ABORT.
REQ-015 IDLE -> LOAD_A on job_start; the row counter SHALL clear to 0.
REQ-016 In LOAD_A and LOAD_B, in_ready SHALL be 1; each in_valid&&in_ready handshake drives addr_pi=row count that cycle, then the counter increments.
REQ-017 Each accepted row SHALL assert data_pi=in_data and we_a (LOAD_A) or we_b (LOAD_B) exactly 2 cycles after the handshake, matching the 2-stage datapath address pipeline.
REQ-018 LOAD_A -> LOAD_B after handshake ROWS-1, with the counter wrapping to 0; LOAD_B -> FLUSH after handshake ROWS-1.
REQ-019 enable_writing_to_mem SHALL be 1 in LOAD_A, LOAD_B and FLUSH; FLUSH SHALL last 2 cycles so the last write lands, with in_ready=0.
REQ-020 Input gaps (in_valid=0) SHALL stall the counter without emitting a write.
REQ-021 COMPUTE SHALL hold start_mat_mul=1 and we_c=1 until the cycle done_mat_mul=1 is sampled; both SHALL drop on the next cycle, and the FSM SHALL enter DRAIN.
REQ-022 DRAIN SHALL hold enable_reading_from_mem=1, issue addr_pi=row r, and capture data_from_out_mat exactly 3 cycles later into out_data with out_valid=1.
REQ-023 out_valid SHALL hold, with out_data stable, until out_ready; the next address SHALL be issued only after the handshake (one read outstanding).
REQ-024 out_last SHALL be 1 with row ROWS-1; its handshake SHALL pulse job_done and return the FSM to IDLE.
REQ-025 job_start outside IDLE SHALL be ignored; done_mat_mul outside COMPUTE SHALL be ignored.
REQ-026 we_a, we_b, we_c and start_mat_mul SHALL never be high outside the states that assert them, including the 2-cycle write tail.

Reset
REQ-027 resetn=0 at any clock edge, including mid-job, SHALL force IDLE, clear the counter and the write pipeline, and set every output to 0 (addr_pi=0, data_pi=0, out_data=0).
REQ-028 After reset deassertion, no datapath write SHALL occur until a new job_start is accepted.

Configuration
REQ-029 With MATMUL_SEQ_CTRL_TIMEOUT_EN defined, a cycle counter SHALL run in COMPUTE.
REQ-030 If TIMEOUT cycles pass without done_mat_mul, the FSM SHALL enter ABORT: start_mat_mul=0, we_c=0, err=1, job_done pulse, then IDLE.
REQ-031 Without MATMUL_SEQ_CTRL_TIMEOUT_EN, COMPUTE SHALL wait indefinitely, err SHALL be tied 0, and the ABORT state SHALL be absent.

Verification
REQ-032 Full job, 32 back-to-back rows, A row i=i and B row i=0x100+i, done at 40 cycles -> A/B BRAM rows 0..15 hold the values, 16 C rows out, out_last on the 16th, one job_done.
REQ-033 in_valid toggling 1-0-1 in LOAD_A -> exactly 16 we_a pulses, addresses 0..15 in order, none duplicated.
REQ-034 out_ready low for 5 cycles on row 3 -> out_data stable, out_valid held, no address 4 issued until the handshake.
REQ-035 resetn low in LOAD_B at row 7 -> next cycle all outputs 0 and IDLE; a new job rewrites A from address 0.
REQ-036 With the macro on, TIMEOUT=64, and done never asserted -> start_mat_mul drops at cycle 64 of COMPUTE, err=1, job_done pulses; err clears on the next job_start.
REQ-037 job_start pulsed during COMPUTE, and done_mat_mul pulsed in IDLE -> no state change, no extra job_done.
